// File: rtl/priv_pkg.sv
// rtl/priv_pkg.sv - privilege mode constants, WFI state type and mode legaliser
package priv_pkg;

    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] S_MODE = 2'b01;
    localparam logic [1:0] U_MODE = 2'b00;

    typedef enum logic {IDLE, WAIT} wfi_state_t;

    // Any encoding that names an unimplemented or reserved mode falls back to M.
    function automatic logic [1:0] legal_mode(input logic [1:0] mode,
                                              input logic       s_ok,
                                              input logic       u_ok);
        logic [1:0] m;
        m = mode;
        if (mode == 2'b10)                m = M_MODE;
        if ((mode == S_MODE) && !s_ok)    m = M_MODE;
        if ((mode == U_MODE) && !u_ok)    m = M_MODE;
        return m;
    endfunction

endpackage

// File: rtl/wfi_timer.sv
// rtl/wfi_timer.sv - TW timeout counter, enable and terminal-count compare
module wfi_timer
    import priv_pkg::*;
#(
    parameter int   WFI_TIMEOUT_BITS = 3,
    parameter logic TO_SUPPORTED     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count_en,
    input  logic       STATUS_TW,
    input  logic [1:0] PrivilegeModeW,
    output logic       toen,
    output logic       terminal
);

    // A zero-width counter is modelled as one bit whose terminal compare is always true.
    localparam int CW = (WFI_TIMEOUT_BITS > 0) ? WFI_TIMEOUT_BITS : 1;

    logic [CW-1:0] count;

    assign toen     = STATUS_TW & (PrivilegeModeW != M_MODE) & TO_SUPPORTED;
    assign terminal = (WFI_TIMEOUT_BITS == 0) | (count == {CW{1'b1}});

    always_ff @(posedge clk) begin
        if (reset || !count_en || !toen) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/privmode_wfi_ctrl.sv
// rtl/privmode_wfi_ctrl.sv - privilege mode register/mux and WFI wait sequencer
module privmode_wfi_ctrl
    import priv_pkg::*;
#(
    parameter logic S_SUPPORTED      = 1'b1,
    parameter logic U_SUPPORTED      = 1'b1,
    parameter int   WFI_TIMEOUT_BITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallW,
    input  logic       TrapM,
    input  logic       mretM,
    input  logic       sretM,
    input  logic       wfiM,
    input  logic       DelegateM,
    input  logic       InterruptPendingM,
    input  logic [1:0] STATUS_MPP,
    input  logic       STATUS_SPP,
    input  logic       STATUS_TW,
    output logic [1:0] PrivilegeModeW,
    output logic [1:0] NextPrivilegeModeM,
    output logic       WFIStallM,
    output logic       WFITimeoutM
);

    wfi_state_t wfi_state, next_state;
    logic       toen, terminal, count_en;
    logic [1:0] raw_mode;

    always_comb begin
        raw_mode = PrivilegeModeW;
        if (TrapM) begin
            if (DelegateM && S_SUPPORTED && (PrivilegeModeW != M_MODE)) raw_mode = S_MODE;
            else                                                        raw_mode = M_MODE;
        end else if (mretM) begin
            raw_mode = STATUS_MPP;
        end else if (sretM) begin
            raw_mode = S_SUPPORTED ? {1'b0, STATUS_SPP} : U_MODE;
        end
    end

    assign NextPrivilegeModeM = legal_mode(raw_mode, S_SUPPORTED, U_SUPPORTED);

    always_ff @(posedge clk) begin
        if (reset)       PrivilegeModeW <= M_MODE;
        else if (!StallW) PrivilegeModeW <= NextPrivilegeModeM;
    end

    // The sequencer deliberately ignores StallW: it is the source of the stall.
    always_ff @(posedge clk) begin
        if (reset) wfi_state <= IDLE;
        else       wfi_state <= next_state;
    end

    always_comb begin
        next_state  = wfi_state;
        WFITimeoutM = 1'b0;
        case (wfi_state)
            IDLE: begin
                if (wfiM && !TrapM && !InterruptPendingM) next_state = WAIT;
            end
            WAIT: begin
                if (InterruptPendingM || TrapM || !wfiM) begin
                    next_state = IDLE;
                end else if (toen && terminal) begin
                    WFITimeoutM = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign WFIStallM = wfiM & ~TrapM & ~InterruptPendingM & ~WFITimeoutM;
    assign count_en  = (wfi_state == WAIT) && (next_state == WAIT);

    wfi_timer #(
        .WFI_TIMEOUT_BITS (WFI_TIMEOUT_BITS),
        .TO_SUPPORTED     (S_SUPPORTED | U_SUPPORTED)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .count_en       (count_en),
        .STATUS_TW      (STATUS_TW),
        .PrivilegeModeW (PrivilegeModeW),
        .toen           (toen),
        .terminal       (terminal)
    );

endmodule

// File: tb/tb_privmode_wfi_ctrl.sv
// tb/tb_privmode_wfi_ctrl.sv - directed vector bench for privmode_wfi_ctrl
module tb_privmode_wfi_ctrl;
    import priv_pkg::*;

    logic       clk = 1'b0;
    logic       reset, StallW, TrapM, mretM, sretM, wfiM, DelegateM, InterruptPendingM;
    logic [1:0] STATUS_MPP;
    logic       STATUS_SPP, STATUS_TW;
    logic [1:0] PrivilegeModeW, NextPrivilegeModeM;
    logic       WFIStallM, WFITimeoutM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    privmode_wfi_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .StallW             (StallW),
        .TrapM              (TrapM),
        .mretM              (mretM),
        .sretM              (sretM),
        .wfiM               (wfiM),
        .DelegateM          (DelegateM),
        .InterruptPendingM  (InterruptPendingM),
        .STATUS_MPP         (STATUS_MPP),
        .STATUS_SPP         (STATUS_SPP),
        .STATUS_TW          (STATUS_TW),
        .PrivilegeModeW     (PrivilegeModeW),
        .NextPrivilegeModeM (NextPrivilegeModeM),
        .WFIStallM          (WFIStallM),
        .WFITimeoutM        (WFITimeoutM)
    );

    typedef struct {
        logic       stallw, trap, mret, sret, wfi, deleg, ip;
        logic [1:0] mpp;
        logic       spp;
        logic [1:0] exp_next, exp_mode;
        logic       exp_stall, exp_to;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        StallW = 0; TrapM = 0; mretM = 0; sretM = 0; wfiM = 0; DelegateM = 0;
        InterruptPendingM = 0; STATUS_MPP = 2'b00; STATUS_SPP = 0; STATUS_TW = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stallw trap mret sret wfi deleg ip  mpp   spp  next   mode   stall to
        vecs[0]  = '{0,1,0,0,0,1,0, 2'b00,0, 2'b11,2'b11, 0,0};
        vecs[1]  = '{0,0,1,0,0,0,0, 2'b00,0, 2'b00,2'b00, 0,0};
        vecs[2]  = '{0,1,0,0,0,1,0, 2'b00,0, 2'b01,2'b01, 0,0};
        vecs[3]  = '{0,0,0,1,0,0,0, 2'b00,0, 2'b00,2'b00, 0,0};
        vecs[4]  = '{0,0,1,0,0,0,0, 2'b10,0, 2'b11,2'b11, 0,0};
        vecs[5]  = '{1,0,1,0,0,0,0, 2'b00,0, 2'b00,2'b11, 0,0};
        vecs[6]  = '{1,0,1,0,0,0,0, 2'b00,0, 2'b00,2'b11, 0,0};
        vecs[7]  = '{0,0,1,0,0,0,0, 2'b00,0, 2'b00,2'b00, 0,0};
        vecs[8]  = '{0,1,1,0,0,0,0, 2'b00,0, 2'b11,2'b11, 0,0};
        vecs[9]  = '{0,0,1,1,0,0,0, 2'b01,0, 2'b01,2'b01, 0,0};
        vecs[10] = '{0,0,0,1,0,0,0, 2'b00,1, 2'b01,2'b01, 0,0};
        vecs[11] = '{0,1,0,0,0,1,0, 2'b00,0, 2'b01,2'b01, 0,0};
        vecs[12] = '{0,0,0,0,0,0,0, 2'b00,0, 2'b01,2'b01, 0,0};
        vecs[13] = '{0,1,0,0,0,0,0, 2'b00,0, 2'b11,2'b11, 0,0};
        vecs[14] = '{0,0,1,0,0,0,0, 2'b01,0, 2'b01,2'b01, 0,0};
        vecs[15] = '{0,0,0,1,0,0,0, 2'b00,0, 2'b00,2'b00, 0,0};
        vecs[16] = '{0,0,0,0,1,0,1, 2'b00,0, 2'b00,2'b00, 0,0};
        vecs[17] = '{0,1,0,0,1,0,0, 2'b00,0, 2'b11,2'b11, 0,0};
        vecs[18] = '{0,0,1,0,0,0,0, 2'b00,0, 2'b00,2'b00, 0,0};

        idle_inputs();
        reset = 1;
        tick();
        tick();
        chk("reset_mode", 32'(PrivilegeModeW), 32'(M_MODE));
        chk("reset_stall", 32'(WFIStallM), 0);
        chk("reset_timeout", 32'(WFITimeoutM), 0);
        chk("reset_state", 32'(dut.wfi_state), 32'(IDLE));
        reset = 0;

        for (int i = 0; i < 19; i++) begin
            StallW = vecs[i].stallw; TrapM = vecs[i].trap; mretM = vecs[i].mret;
            sretM = vecs[i].sret; wfiM = vecs[i].wfi; DelegateM = vecs[i].deleg;
            InterruptPendingM = vecs[i].ip; STATUS_MPP = vecs[i].mpp; STATUS_SPP = vecs[i].spp;
            #1;
            chk($sformatf("vec%0d_next", i), 32'(NextPrivilegeModeM), 32'(vecs[i].exp_next));
            chk($sformatf("vec%0d_stall", i), 32'(WFIStallM), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_timeout", i), 32'(WFITimeoutM), 32'(vecs[i].exp_to));
            tick();
            chk($sformatf("vec%0d_mode", i), 32'(PrivilegeModeW), 32'(vecs[i].exp_mode));
        end

        // TW timeout from U mode: 8 stalled cycles then a single timeout pulse.
        idle_inputs();
        STATUS_TW = 1; wfiM = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("to_u_stall%0d", k), 32'(WFIStallM), 1);
            chk($sformatf("to_u_to%0d", k), 32'(WFITimeoutM), 0);
            tick();
        end
        #1;
        chk("to_u_pulse", 32'(WFITimeoutM), 1);
        chk("to_u_pulse_stall", 32'(WFIStallM), 0);
        tick();
        wfiM = 0;
        #1;
        chk("to_u_idle", 32'(dut.wfi_state), 32'(IDLE));
        chk("to_u_after", 32'(WFITimeoutM), 0);
        tick();

        // M mode: TW has no effect, wait is indefinite until an interrupt.
        TrapM = 1;
        tick();
        TrapM = 0;
        chk("m_mode", 32'(PrivilegeModeW), 32'(M_MODE));
        wfiM = 1;
        for (int k = 0; k < 50; k++) begin
            #1;
            chk($sformatf("m_stall%0d", k), 32'(WFIStallM), 1);
            chk($sformatf("m_to%0d", k), 32'(WFITimeoutM), 0);
            tick();
        end
        chk("m_count", 32'(dut.u_timer.count), 0);
        InterruptPendingM = 1;
        #1;
        chk("m_wake_stall", 32'(WFIStallM), 0);
        chk("m_wake_to", 32'(WFITimeoutM), 0);
        tick();
        chk("m_wake_idle", 32'(dut.wfi_state), 32'(IDLE));
        InterruptPendingM = 0; wfiM = 0;

        // S mode: interrupt on the terminal-count cycle beats the timeout.
        mretM = 1; STATUS_MPP = 2'b01;
        tick();
        mretM = 0;
        chk("s_mode", 32'(PrivilegeModeW), 32'(S_MODE));
        wfiM = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("s_stall%0d", k), 32'(WFIStallM), 1);
            tick();
        end
        InterruptPendingM = 1;
        #1;
        chk("s_race_to", 32'(WFITimeoutM), 0);
        chk("s_race_stall", 32'(WFIStallM), 0);
        tick();
        chk("s_race_idle", 32'(dut.wfi_state), 32'(IDLE));
        InterruptPendingM = 0;

        // Reset in the middle of a wait aborts it without a timeout.
        tick();
        tick();
        chk("s_rewait", 32'(dut.wfi_state), 32'(WAIT));
        chk("s_rewait_count", 32'(dut.u_timer.count), 1);
        reset = 1;
        #1;
        chk("rst_wait_to", 32'(WFITimeoutM), 0);
        tick();
        chk("rst_wait_state", 32'(dut.wfi_state), 32'(IDLE));
        chk("rst_wait_count", 32'(dut.u_timer.count), 0);
        chk("rst_wait_mode", 32'(PrivilegeModeW), 32'(M_MODE));
        chk("rst_wait_timeout", 32'(WFITimeoutM), 0);
        reset = 0; wfiM = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
